// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a 4*NIBBLES-bit operation through a shared external
// 4-bit ALU one nibble per cycle, chaining the carry between passes.
//
//   state | meaning
//   IDLE  | ready for start; result/cout hold the last operation
//   RUN   | one ALU pass per cycle on nibble idx
//   DONE  | single-cycle done pulse, then back to IDLE
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic [3:0]             s_in,
    input  logic                   m_in,
    input  logic                   cin_in,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cin,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cout,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   done
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [4*NIBBLES-1:0]   a_reg;
    logic [4*NIBBLES-1:0]   b_reg;
    logic [3:0]             s_reg;
    logic                   m_reg;
    logic                   cin_reg;
    logic                   carry_reg;

    // ALU drive: only latched registers feed the ALU, and only while running
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = '0;
        alu_m   = 1'b0;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_s   = s_reg;
            alu_m   = m_reg;
            alu_cin = (idx == '0) ? cin_reg : carry_reg;
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) begin
                    alu_a = a_reg[4*i +: 4];
                    alu_b = b_reg[4*i +: 4];
                end
            end
        end
    end

    // Sequencer FSM with registered ready/done/result/cout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            cin_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        s_reg     <= s_in;
                        m_reg     <= m_in;
                        cin_reg   <= cin_in;
                        idx       <= '0;
                        result    <= '0;
                        carry_reg <= 1'b0;
                        ready     <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IW'(i)) begin
                            result[4*i +: 4] <= alu_f;
                        end
                    end
                    carry_reg <= alu_cout;
                    if (idx == IW'(NIBBLES - 1)) begin
                        // idx stays put on the last pass so it never wraps
                        cout  <= alu_cout;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
